req_gnt_window_monitor: RTL and testbench

- Synthesizable, multi-channel request/grant protocol checker.
- Each channel implements the hardware equivalent of the property "$rose(req) |-> ##[MIN_DLY:MAX_DLY] gnt", plus optional req-stability and spurious-grant checks.
- Reports per-attempt pass/fail pulses, sticky error flags, fail causes, measured latency and saturating global pass/fail counters.
- Sits beside bus arbiters in emulation/FPGA builds where simulator assertions are unavailable.

---
 rtl/req_gnt_window_monitor.sv | 221 ++++++++++++++++++++++
 tb/tb_req_gnt_window_monitor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_gnt_window_monitor.sv
// req_gnt_window_monitor
//   Multi-channel request/grant window checker. Each channel checks the
//   property "$rose(req) |-> ##[MIN_DLY:MAX_DLY] gnt". It can also flag a
//   req that drops before its grant and a grant that arrives with no
//   attempt pending.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : checking enable; while low every channel sits in IDLE
//   clear        : synchronous clear of err_sticky, fail_cause and counters
//   req, gnt     : per-channel request / grant       [NUM_CH]
//   pass, fail   : 1-cycle verdict pulses             [NUM_CH]
//   err_sticky   : set on any fail, held until clear  [NUM_CH]
//   fail_cause   : 3 bits per channel: 0 none, 1 early, 2 timeout,
//                  3 req drop, 4 spurious gnt         [3*NUM_CH]
//   last_lat     : grant delay k of the last pass     [LAT_W*NUM_CH]
//   pass_cnt,
//   fail_cnt     : saturating global totals           [CNT_W]

// Per-channel checker. pass_nxt/fail_nxt are the verdicts being decided
// this cycle. The top level needs them to update its counters on the
// same edge that the registered pulses assert.
module req_gnt_window_ch #(
   parameter int MIN_DLY      = 4,
   parameter int MAX_DLY      = 32,
   parameter bit CHECK_STABLE = 1'b1,
   parameter int LAT_W        = $clog2(MAX_DLY+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic             req,
   input  logic             gnt,
   output logic             pass_nxt,
   output logic             fail_nxt,
   output logic             pass,
   output logic             fail,
   output logic             err_sticky,
   output logic [2:0]       fail_cause,
   output logic [LAT_W-1:0] last_lat
);
   localparam int CW = $clog2(MAX_DLY+1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          state, st_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [2:0]      cause_nxt;
   logic [CW-1:0]   lat_nxt;
   logic            req_q;
   logic            rise;

   // req_q is always valid, so a rise seen on the first enabled cycle counts.
   assign rise = req & ~req_q;

   always_comb begin
      st_nxt    = state;
      cnt_nxt   = cnt;
      pass_nxt  = 1'b0;
      fail_nxt  = 1'b0;
      cause_nxt = 3'd0;
      lat_nxt   = cnt;
      if (!en) begin
         // An attempt pending at this point is dropped without a verdict.
         st_nxt  = IDLE;
         cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (rise && gnt) begin
                  // The grant arrives on the rise sample itself, so k=0.
                  lat_nxt = '0;
                  if (MIN_DLY == 0) pass_nxt = 1'b1;
                  else begin
                     fail_nxt  = 1'b1;
                     cause_nxt = 3'd1;
                  end
               end else if (rise) begin
                  st_nxt  = WAIT;
                  cnt_nxt = CW'(1);
               end else if (gnt) begin
                  fail_nxt  = 1'b1;
                  cause_nxt = 3'd4;
               end
            end
            WAIT: begin
               // Order of checks: grant verdict, then req drop, then timeout.
               // A grant is judged even when req is low on the same sample.
               if (gnt) begin
                  st_nxt = IDLE;
                  if (cnt >= CW'(MIN_DLY)) pass_nxt = 1'b1;
                  else begin
                     fail_nxt  = 1'b1;
                     cause_nxt = 3'd1;
                  end
               end else if (CHECK_STABLE && !req) begin
                  st_nxt    = IDLE;
                  fail_nxt  = 1'b1;
                  cause_nxt = 3'd3;
               end else if (cnt == CW'(MAX_DLY)) begin
                  st_nxt    = IDLE;
                  fail_nxt  = 1'b1;
                  cause_nxt = 3'd2;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            default: st_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         req_q      <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         err_sticky <= 1'b0;
         fail_cause <= 3'd0;
         last_lat   <= '0;
      end else begin
         state <= st_nxt;
         cnt   <= cnt_nxt;
         req_q <= req;
         pass  <= pass_nxt;
         fail  <= fail_nxt;
         // A verdict on the same cycle as clear wins over the clear.
         if (clear) begin
            err_sticky <= 1'b0;
            fail_cause <= 3'd0;
         end
         if (fail_nxt) begin
            err_sticky <= 1'b1;
            fail_cause <= cause_nxt;
         end
         if (pass_nxt) last_lat <= LAT_W'(lat_nxt);
      end
   end
endmodule

module req_gnt_window_monitor #(
   parameter int NUM_CH       = 4,
   parameter int MIN_DLY      = 4,
   parameter int MAX_DLY      = 32,
   parameter bit CHECK_STABLE = 1'b1,
   parameter int CNT_W        = 16,
   parameter int LAT_W        = $clog2(MAX_DLY+1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    clear,
   input  logic [NUM_CH-1:0]       req,
   input  logic [NUM_CH-1:0]       gnt,
   output logic [NUM_CH-1:0]       pass,
   output logic [NUM_CH-1:0]       fail,
   output logic [NUM_CH-1:0]       err_sticky,
   output logic [3*NUM_CH-1:0]     fail_cause,
   output logic [LAT_W*NUM_CH-1:0] last_lat,
   output logic [CNT_W-1:0]        pass_cnt,
   output logic [CNT_W-1:0]        fail_cnt
);
   localparam int PCW = $clog2(NUM_CH+1);
   localparam int SW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;

   logic [NUM_CH-1:0] pass_nxt, fail_nxt;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      req_gnt_window_ch #(
         .MIN_DLY      (MIN_DLY),
         .MAX_DLY      (MAX_DLY),
         .CHECK_STABLE (CHECK_STABLE),
         .LAT_W        (LAT_W)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .en         (en),
         .clear      (clear),
         .req        (req[g]),
         .gnt        (gnt[g]),
         .pass_nxt   (pass_nxt[g]),
         .fail_nxt   (fail_nxt[g]),
         .pass       (pass[g]),
         .fail       (fail[g]),
         .err_sticky (err_sticky[g]),
         .fail_cause (fail_cause[3*g +: 3]),
         .last_lat   (last_lat[LAT_W*g +: LAT_W])
      );
   end

   function automatic logic [PCW-1:0] popcnt(input logic [NUM_CH-1:0] v);
      logic [PCW-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_CH; i++) n = n + PCW'(v[i]);
      return n;
   endfunction

   // The sum is computed wide enough that any overflow shows up in the
   // bits above CNT_W, which then forces the counter to all ones.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [PCW-1:0]   b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      if (s[SW-1:CNT_W] != '0) return '1;
      return s[CNT_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else begin
         // Clear comes first; this cycle's verdicts are added on top of it.
         pass_cnt <= sat_add(clear ? '0 : pass_cnt, popcnt(pass_nxt));
         fail_cnt <= sat_add(clear ? '0 : fail_cnt, popcnt(fail_nxt));
      end
   end
endmodule

// File: tb/tb_req_gnt_window_monitor.sv
module tb_req_gnt_window_monitor;
   localparam int NC = 4;
   localparam int LW = 6;

   logic            clk = 1'b0;
   logic            rst_n, en, clear;
   logic [NC-1:0]   req, gnt, req2, gnt2;
   logic [NC-1:0]   pass, fail, err_sticky, pass2, fail2, err_sticky2;
   logic [3*NC-1:0] fail_cause, fail_cause2;
   logic [LW*NC-1:0] last_lat, last_lat2;
   logic [15:0]     pass_cnt, fail_cnt;
   logic [3:0]      pass_cnt2, fail_cnt2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Main instance: default parameters.
   req_gnt_window_monitor dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .req(req), .gnt(gnt),
      .pass(pass), .fail(fail), .err_sticky(err_sticky), .fail_cause(fail_cause),
      .last_lat(last_lat), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
   );

   // Second instance: req level ignored while waiting, narrow counters.
   req_gnt_window_monitor #(.CHECK_STABLE(1'b0), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .req(req2), .gnt(gnt2),
      .pass(pass2), .fail(fail2), .err_sticky(err_sticky2), .fail_cause(fail_cause2),
      .last_lat(last_lat2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s", tag);
      end
   endtask

   // Raise req on ch, grant exactly k cycles after the rise sample; on
   // return the verdict pulse is visible.
   task automatic attempt(input int ch, input int k);
      req[ch] = 1'b1;
      if (k == 0) gnt[ch] = 1'b1;
      tick();
      for (int i = 1; i <= k; i++) begin
         if (i == k) gnt[ch] = 1'b1;
         tick();
      end
   endtask

   task automatic release_ch(input int ch);
      req[ch] = 1'b0;
      gnt[ch] = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; clear = 1'b0;
      req = '0; gnt = '0; req2 = '0; gnt2 = '0;
      #12;
      chk("rst_pass_fail", {pass, fail}, 0);
      chk("rst_sticky_cause", {err_sticky, fail_cause}, 0);
      chk("rst_cnts", {pass_cnt, fail_cnt}, 0);
      chk("rst_lat", last_lat, 0);
      tick();
      rst_n = 1'b1; en = 1'b1;
      tick();

      // ch0 legal grant at k=4 (minimum boundary)
      attempt(0, 4);
      chk("ch0_pass", pass, 4'b0001);
      chk("ch0_lat", last_lat[5:0], 4);
      chk("ch0_pass_cnt", pass_cnt, 1);
      chk("ch0_sticky", err_sticky, 0);
      release_ch(0);
      chk("ch0_pulse_1cyc", pass, 0);

      // ch1 early grant k=2, then grant at k=32 (maximum boundary)
      attempt(1, 2);
      chk("ch1_early_fail", fail, 4'b0010);
      chk("ch1_early_cause", fail_cause[5:3], 1);
      chk("ch1_sticky", err_sticky, 4'b0010);
      chk("ch1_fail_cnt", fail_cnt, 1);
      release_ch(1);
      attempt(1, 32);
      chk("ch1_max_pass", pass, 4'b0010);
      chk("ch1_max_lat", last_lat[11:6], 32);
      chk("ch1_cnts", {pass_cnt, fail_cnt}, {16'd2, 16'd1});
      release_ch(1);

      // ch2 timeout with req held high
      req[2] = 1'b1;
      tick();
      repeat (31) tick();
      chk("ch2_no_fail_k31", fail, 0);
      tick();
      chk("ch2_timeout", fail, 4'b0100);
      chk("ch2_cause", fail_cause[8:6], 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ch2_no_reattempt", {pass[2], fail[2]}, 0);
      end
      chk("ch2_fail_cnt", fail_cnt, 2);
      req[2] = 1'b0;
      tick();

      // ch3 req drop at k=3; dut2 ignores the drop and times out at k=32
      req[3] = 1'b1; req2[3] = 1'b1;
      tick(); tick(); tick();
      req[3] = 1'b0; req2[3] = 1'b0;
      tick();
      chk("ch3_drop_fail", fail, 4'b1000);
      chk("ch3_drop_cause", fail_cause[11:9], 3);
      chk("ch3_nostable_quiet", fail2, 0);
      repeat (28) tick();
      chk("ch3_nostable_k31", fail2, 0);
      tick();
      chk("ch3_nostable_timeout", fail2, 4'b1000);
      chk("ch3_nostable_cause", fail_cause2[11:9], 2);

      // spurious grant on idle ch0
      gnt[0] = 1'b1;
      tick();
      gnt[0] = 1'b0;
      chk("spur_fail", fail, 4'b0001);
      chk("spur_cause", fail_cause[2:0], 4);
      chk("spur_sticky_all", err_sticky, 4'b1111);
      chk("spur_fail_cnt", fail_cnt, 4);

      // clear: counters/flags zeroed, last_lat kept
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_cnts", {pass_cnt, fail_cnt}, 0);
      chk("clr_sticky_cause", {err_sticky, fail_cause}, 0);
      chk("clr_lat_kept", last_lat[5:0], 4);
      chk("clr_cnt2", fail_cnt2, 0);

      // saturation on 4-bit counters: 12, 14, then 4 more -> 15
      gnt2 = 4'hF;
      repeat (3) tick();
      gnt2 = 4'b0011;
      tick();
      chk("sat_pre", fail_cnt2, 14);
      gnt2 = 4'hF;
      tick();
      chk("sat_all_fail", fail2, 4'hF);
      chk("sat_hit", fail_cnt2, 15);
      tick();
      chk("sat_hold", fail_cnt2, 15);
      gnt2 = '0;
      tick();

      // async reset in the middle of a WAIT on ch0
      gnt[1] = 1'b1; req[0] = 1'b1;
      tick();
      gnt[1] = 1'b0;
      tick();
      chk("prerst_fail_cnt", fail_cnt, 1);
      rst_n = 1'b0; req = '0;
      #1;
      chk("rst_async_cnts", {pass_cnt, fail_cnt}, 0);
      chk("rst_async_sticky", err_sticky, 0);
      chk("rst_async_lat", last_lat, 0);
      #10;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("postrst_quiet", {pass, fail}, 0);
      end

      // en dropped mid-WAIT: the late grant is ignored, no new attempt
      req[1] = 1'b1;
      tick(); tick();
      en = 1'b0;
      tick();
      gnt[1] = 1'b1;
      tick();
      chk("en_off_quiet", {pass, fail}, 0);
      en = 1'b1; gnt[1] = 1'b0;
      tick();
      chk("en_on_no_rise", {pass, fail}, 0);
      req[1] = 1'b0;
      tick();

      // rise on the first enabled cycle counts
      en = 1'b0;
      tick();
      en = 1'b1;
      attempt(2, 5);
      chk("en_first_pass", pass, 4'b0100);
      chk("en_first_lat", last_lat[17:12], 5);
      chk("en_first_cnt", pass_cnt, 1);
      release_ch(2);

      // clear coincident with a verdict
      gnt[0] = 1'b1;
      tick();
      gnt[0] = 1'b0;
      chk("pre_clr_sticky", err_sticky, 4'b0001);
      gnt[3] = 1'b1; clear = 1'b1;
      tick();
      gnt[3] = 1'b0; clear = 1'b0;
      chk("clr_coinc_fail_cnt", fail_cnt, 1);
      chk("clr_coinc_sticky", err_sticky, 4'b1000);
      chk("clr_coinc_cause", fail_cause, 12'h800);
      chk("clr_coinc_pass_cnt", pass_cnt, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
